// File: rtl/ycbcr_mode_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ycbcr_mode_ctrl_pkg
// Shared definitions for the YCbCr output mode controller:
//   - output mode encodings (bypass RGB, YCbCr, grey, binary)
//   - default converter latency
//   - controller FSM state encoding
// ---------------------------------------------------------------------------
package ycbcr_mode_ctrl_pkg;

    localparam int CONV_LAT_DEF = 7;
    localparam int PIX_W        = 24;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_YCBCR  = 2'd1,
        MODE_GREY   = 2'd2,
        MODE_BIN    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

endpackage

// File: rtl/ycbcr_mode_ctrl_delayline.sv
// ---------------------------------------------------------------------------
// ycbcr_mode_ctrl_delayline
// Fixed-length shift register delay for a bundle of N bits. Used to align the
// raw {de,hsync,vsync,pixel} stream with the converter output.
// Ports:
//   clk   in  1  clock
//   din   in  N  bundle in
//   dout  out N  bundle delayed by DELAY cycles (DELAY >= 1)
// Data-only path: no reset, contents flush naturally after DELAY cycles.
// ---------------------------------------------------------------------------
module ycbcr_mode_ctrl_delayline #(
    parameter int N     = 27,
    parameter int DELAY = 7
) (
    input  logic         clk,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);

    logic [N-1:0] taps [DELAY];

    always_ff @(posedge clk) begin
        taps[0] <= din;
        for (int i = 1; i < DELAY; i++) begin
            taps[i] <= taps[i-1];
        end
    end

    assign dout = taps[DELAY-1];

endmodule

// File: rtl/ycbcr_mode_ctrl.sv
// ---------------------------------------------------------------------------
// ycbcr_mode_ctrl
// Frame-synchronous output mode controller behind the rgb2ycbcr converter.
// Per frame it selects bypass RGB, YCbCr, grey ({Y,Y,Y}) or binary
// (Y >= threshold -> white). Host configuration arrives on a valid/ready
// handshake, is held in a shadow register and only takes effect at a frame
// start (rising edge of conv_vsync), so a frame never mixes modes.
//
// Optional feature macro: YCM_STATS_EN
//   defined   -> line_len / frame_lines / frame_cnt status counters active
//   undefined -> counters omitted, status outputs tied to 0
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   hsync_in/vsync_in/de_in       raw stream timing (converter input timing)
//   pixel_in[23:0]                raw {R,G,B}
//   conv_hsync/vsync/de           converter timing, CONV_LAT after raw
//   conv_pixel[23:0]              converter {Y,Cb,Cr}
//   cfg_valid/cfg_ready           host config handshake
//   cfg_mode[1:0], cfg_thresh[7:0] requested mode and binary threshold
//   hsync_out/vsync_out/de_out    conv timing delayed by one cycle
//   pixel_out[23:0]               selected output pixel
//   active_mode[1:0]              mode in force for the current frame
//   frame_cnt[15:0]               frame starts since reset (wraps)
//   line_len[CNT_W-1:0]           de-high pixels in last complete line
//   frame_lines[CNT_W-1:0]        lines in last complete frame
// Latency input -> pixel_out is CONV_LAT+1 in every mode.
// ---------------------------------------------------------------------------
module ycbcr_mode_ctrl
    import ycbcr_mode_ctrl_pkg::*;
#(
    parameter int CONV_LAT = CONV_LAT_DEF,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             de_in,
    input  logic [23:0]      pixel_in,
    input  logic             conv_hsync,
    input  logic             conv_vsync,
    input  logic             conv_de,
    input  logic [23:0]      conv_pixel,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [7:0]       cfg_thresh,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             de_out,
    output logic [23:0]      pixel_out,
    output logic [1:0]       active_mode,
    output logic [15:0]      frame_cnt,
    output logic [CNT_W-1:0] line_len,
    output logic [CNT_W-1:0] frame_lines
);

    function automatic logic [23:0] mode_pixel(
        input mode_t       mode,
        input logic [23:0] rgb,
        input logic [23:0] ycc,
        input logic [7:0]  thresh
    );
        logic [7:0]  y;
        logic [23:0] res;
        y = ycc[23:16];
        case (mode)
            MODE_BYPASS: res = rgb;
            MODE_YCBCR:  res = ycc;
            MODE_GREY:   res = {y, y, y};
            MODE_BIN:    res = (y >= thresh) ? 24'hFFFFFF : 24'h000000;
            default:     res = rgb;
        endcase
        return res;
    endfunction

    // ---- bypass alignment: raw stream delayed to converter timing ----
    logic [26:0] dl_out;
    logic [23:0] rgb_p0;

    ycbcr_mode_ctrl_delayline #(
        .N     (27),
        .DELAY (CONV_LAT)
    ) u_delayline (
        .clk  (clk),
        .din  ({de_in, hsync_in, vsync_in, pixel_in}),
        .dout (dl_out)
    );

    assign rgb_p0 = dl_out[23:0];

    // Delayed raw timing is carried in the bundle but timing is taken from conv_*.
    logic unused_dl_timing;
    assign unused_dl_timing = ^dl_out[26:24];

    // ---- frame start detection ----
    logic vsync_p1;
    logic fs;

    always_ff @(posedge clk) begin
        if (rst) vsync_p1 <= 1'b0;
        else     vsync_p1 <= conv_vsync;
    end

    assign fs = conv_vsync & ~vsync_p1;

    // ---- config FSM ----
    state_t      state, state_nxt;
    logic        handshake;
    logic        apply;
    mode_t       shadow_mode, act_mode;
    logic [7:0]  shadow_thresh, act_thresh;
    mode_t       mode_now;
    logic [7:0]  thresh_now;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b1;
        handshake = 1'b0;
        apply     = 1'b0;
        case (state)
            ST_IDLE, ST_RUN: begin
                handshake = cfg_valid;
                if (cfg_valid) state_nxt = ST_PENDING;
            end
            ST_PENDING: begin
                cfg_ready = 1'b0;
                // A handshake can only happen outside PENDING, so a config
                // arriving on an FS cycle waits for the following FS.
                if (fs) begin
                    apply     = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_mode   <= MODE_BYPASS;
            shadow_thresh <= 8'd0;
            act_mode      <= MODE_BYPASS;
            act_thresh    <= 8'd0;
        end else begin
            if (handshake) begin
                shadow_mode   <= mode_t'(cfg_mode);
                shadow_thresh <= cfg_thresh;
            end
            if (apply) begin
                act_mode   <= shadow_mode;
                act_thresh <= shadow_thresh;
            end
        end
    end

    // The FS cycle itself already uses the newly applied mode.
    assign mode_now    = apply ? shadow_mode   : act_mode;
    assign thresh_now  = apply ? shadow_thresh : act_thresh;
    assign active_mode = act_mode;

    // ---- output register stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            de_out    <= 1'b0;
            pixel_out <= 24'd0;
        end else begin
            hsync_out <= conv_hsync;
            vsync_out <= conv_vsync;
            de_out    <= conv_de;
            pixel_out <= conv_de ? mode_pixel(mode_now, rgb_p0, conv_pixel, thresh_now)
                                 : 24'd0;
        end
    end

`ifdef YCM_STATS_EN
    // ---- status counters (saturating line/pixel counts, wrapping frame count) ----
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             de_p1;
    logic             de_rise, de_fall;
    logic [CNT_W-1:0] pix_cnt, line_cnt;

    assign de_rise = conv_de & ~de_p1;
    assign de_fall = ~conv_de & de_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            de_p1       <= 1'b0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            frame_cnt   <= 16'd0;
        end else begin
            de_p1 <= conv_de;

            if (de_fall) begin
                line_len <= pix_cnt;
                pix_cnt  <= '0;
            end else if (conv_de && pix_cnt != CNT_MAX) begin
                pix_cnt <= pix_cnt + CNT_ONE;
            end

            // A line starting on the FS cycle belongs to the new frame.
            if (fs) begin
                frame_lines <= line_cnt;
                line_cnt    <= de_rise ? CNT_ONE : '0;
                frame_cnt   <= frame_cnt + 16'd1;
            end else if (de_rise && line_cnt != CNT_MAX) begin
                line_cnt <= line_cnt + CNT_ONE;
            end
        end
    end
`else
    assign line_len    = '0;
    assign frame_lines = '0;
    assign frame_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_ycbcr_mode_ctrl.sv
module tb_ycbcr_mode_ctrl;

    localparam int CONV_LAT = 7;
    localparam int CNT_W    = 12;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             hsync_in, vsync_in, de_in;
    logic [23:0]      pixel_in;
    logic             conv_hsync, conv_vsync, conv_de;
    logic [23:0]      conv_pixel;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_mode;
    logic [7:0]       cfg_thresh;
    logic             hsync_out, vsync_out, de_out;
    logic [23:0]      pixel_out;
    logic [1:0]       active_mode;
    logic [15:0]      frame_cnt;
    logic [CNT_W-1:0] line_len;
    logic [CNT_W-1:0] frame_lines;

    ycbcr_mode_ctrl #(.CONV_LAT(CONV_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in), .pixel_in(pixel_in),
        .conv_hsync(conv_hsync), .conv_vsync(conv_vsync), .conv_de(conv_de),
        .conv_pixel(conv_pixel),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
        .cfg_thresh(cfg_thresh),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
        .pixel_out(pixel_out), .active_mode(active_mode), .frame_cnt(frame_cnt),
        .line_len(line_len), .frame_lines(frame_lines)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // raw stream history; the converter is emulated as a pure CONV_LAT delay
    logic [26:0] hist [256];
    int force_y = -1;
    int inj_cyc = -1, inj_mode = 0, inj_th = 0;
    bit pin_on = 0;
    logic [23:0] pin_val;
    int pin_hits = 0;

    // reference model state: scheduled vs. in-force configuration, statistics
    bit  m_prev_vs, m_prev_de, m_pend;
    int  m_sh_mode, m_sh_th, m_act_mode, m_act_th;
    int  m_pix, m_lines, m_line_len, m_frame_lines, m_frame_cnt;
    logic        e_hs, e_vs, e_de, e_ready;
    logic [23:0] e_pix;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model(input logic [23:0] raw_rgb);
        bit fs, hs, rise, fall;
        logic [7:0] y;
        if (rst) begin
            m_prev_vs = 0; m_prev_de = 0; m_pend = 0;
            m_sh_mode = 0; m_sh_th = 0; m_act_mode = 0; m_act_th = 0;
            m_pix = 0; m_lines = 0; m_line_len = 0; m_frame_lines = 0; m_frame_cnt = 0;
            e_hs = 0; e_vs = 0; e_de = 0; e_pix = 24'd0; e_ready = 1;
            return;
        end
        fs = conv_vsync && !m_prev_vs;
        hs = cfg_valid && !m_pend;
        if (fs && m_pend) begin
            m_act_mode = m_sh_mode; m_act_th = m_sh_th; m_pend = 0;
        end
        if (hs) begin
            m_sh_mode = int'(cfg_mode); m_sh_th = int'(cfg_thresh); m_pend = 1;
        end
        e_ready = !m_pend;
        e_hs = conv_hsync; e_vs = conv_vsync; e_de = conv_de;
        y = conv_pixel[23:16];
        if (!conv_de)            e_pix = 24'd0;
        else if (m_act_mode == 0) e_pix = raw_rgb;
        else if (m_act_mode == 1) e_pix = conv_pixel;
        else if (m_act_mode == 2) e_pix = {y, y, y};
        else                      e_pix = (int'(y) >= m_act_th) ? 24'hFFFFFF : 24'h000000;
        rise = conv_de && !m_prev_de;
        fall = !conv_de && m_prev_de;
        if (fall) begin
            m_line_len = m_pix; m_pix = 0;
        end else if (conv_de && m_pix < CMAX) m_pix++;
        if (fs) begin
            m_frame_lines = m_lines; m_lines = rise ? 1 : 0;
            m_frame_cnt = (m_frame_cnt + 1) % 65536;
        end else if (rise && m_lines < CMAX) m_lines++;
        m_prev_vs = conv_vsync; m_prev_de = conv_de;
    endtask

    // one clock: drive converter side, update model, check all outputs
    task automatic step();
        logic [26:0] d;
        logic [31:0] r;
        if (cyc == inj_cyc) begin
            cfg_valid = 1'b1; cfg_mode = inj_mode[1:0]; cfg_thresh = inj_th[7:0];
        end
        hist[cyc & 255] = {de_in, hsync_in, vsync_in, pixel_in};
        d = (cyc >= CONV_LAT) ? hist[(cyc - CONV_LAT) & 255] : 27'd0;
        r = $urandom;
        conv_de = d[26]; conv_hsync = d[25]; conv_vsync = d[24];
        conv_pixel = {(force_y >= 0) ? force_y[7:0] : r[31:24], r[15:0]};
        model(d[23:0]);
        @(posedge clk);
        #1;
        check("hsync_out", 32'(hsync_out), 32'(e_hs));
        check("vsync_out", 32'(vsync_out), 32'(e_vs));
        check("de_out", 32'(de_out), 32'(e_de));
        check("pixel_out", 32'(pixel_out), 32'(e_pix));
        check("cfg_ready", 32'(cfg_ready), 32'(e_ready));
        check("active_mode", 32'(active_mode), 32'(m_act_mode));
`ifdef YCM_STATS_EN
        check("line_len", 32'(line_len), 32'(m_line_len));
        check("frame_lines", 32'(frame_lines), 32'(m_frame_lines));
        check("frame_cnt", 32'(frame_cnt), 32'(m_frame_cnt));
`else
        check("line_len", 32'(line_len), 32'd0);
        check("frame_lines", 32'(frame_lines), 32'd0);
        check("frame_cnt", 32'(frame_cnt), 32'd0);
`endif
        if (pin_on && e_de) begin
            pin_hits++;
            check("pin_pixel", 32'(pixel_out), 32'(pin_val));
        end
        cfg_valid = 1'b0;
        cyc++;
    endtask

    // one frame: vsync pulse, w x h active area, drain tail; optional config
    // injected inj_off cycles after the raw vsync rise (CONV_LAT == FS cycle)
    task automatic frame(input int w, input int h, input int off, input int md, input int th);
        logic [31:0] r;
        if (off >= 0) begin
            inj_cyc = cyc + off; inj_mode = md; inj_th = th;
        end
        vsync_in = 1; step(); step();
        vsync_in = 0; step(); step();
        for (int l = 0; l < h; l++) begin
            for (int p = 0; p < w; p++) begin
                r = $urandom;
                de_in = 1; pixel_in = r[23:0]; step();
            end
            de_in = 0; pixel_in = 24'd0;
            hsync_in = 1; step();
            hsync_in = 0; step(); step();
        end
        for (int t = 0; t < CONV_LAT + 3; t++) step();
    endtask

    task automatic fs_only();
        vsync_in = 1; step(); step();
        vsync_in = 0;
        for (int t = 0; t < CONV_LAT + 3; t++) step();
    endtask

    task automatic do_reset();
        rst = 1; step(); step(); rst = 0;
    endtask

    initial begin
        rst = 1; hsync_in = 0; vsync_in = 0; de_in = 0; pixel_in = 24'd0;
        cfg_valid = 0; cfg_mode = 2'd0; cfg_thresh = 8'd0;
        conv_hsync = 0; conv_vsync = 0; conv_de = 0; conv_pixel = 24'd0;
        for (int i = 0; i < 256; i++) hist[i] = 27'd0;

        step(); step(); step();
        rst = 0;
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_mode", 32'(active_mode), 32'd0);
        check("rst_pixel", 32'(pixel_out), 32'd0);

        // two plain frames, bypass
        frame(4, 3, -1, 0, 0);
        frame(4, 3, -1, 0, 0);
        check("bypass_mode", 32'(active_mode), 32'd0);

        // mid-frame config after FS -> pending, applied next frame
        frame(4, 3, CONV_LAT + 8, 1, 0);
        check("mid_ready", 32'(cfg_ready), 32'd0);
        check("mid_mode_hold", 32'(active_mode), 32'd0);
        frame(4, 3, -1, 0, 0);
        check("mid_mode_new", 32'(active_mode), 32'd1);

        // binary mode, threshold 0x80 (config before FS of same frame)
        force_y = 8'h80; pin_on = 1; pin_val = 24'hFFFFFF; pin_hits = 0;
        frame(4, 2, 2, 3, 8'h80);
        check("bin_hi_seen", 32'(pin_hits != 0), 32'd1);
        force_y = 8'h7F; pin_val = 24'h000000; pin_hits = 0;
        frame(4, 2, -1, 0, 0);
        check("bin_lo_seen", 32'(pin_hits != 0), 32'd1);
        pin_on = 0;

        // config on the FS cycle -> not applied this frame
        frame(4, 2, CONV_LAT, 2, 0);
        check("fs_cfg_hold", 32'(active_mode), 32'd3);
        check("fs_cfg_ready", 32'(cfg_ready), 32'd0);
        force_y = 8'h5A; pin_on = 1; pin_val = 24'h5A5A5A; pin_hits = 0;
        frame(4, 2, -1, 0, 0);
        check("fs_cfg_new", 32'(active_mode), 32'd2);
        check("grey_seen", 32'(pin_hits != 0), 32'd1);
        pin_on = 0; force_y = -1;

        // statistics: 640 x 3 frame after reset
        do_reset();
        frame(640, 3, -1, 0, 0);
        fs_only();
`ifdef YCM_STATS_EN
        check("stat_line_len", 32'(line_len), 32'd640);
        check("stat_frame_lines", 32'(frame_lines), 32'd3);
        check("stat_frame_cnt", 32'(frame_cnt), 32'd2);
`else
        check("stat_line_len", 32'(line_len), 32'd0);
        check("stat_frame_lines", 32'(frame_lines), 32'd0);
        check("stat_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
        // saturation of the pixel counter
        frame(4100, 1, -1, 0, 0);
        fs_only();
`ifdef YCM_STATS_EN
        check("sat_line_len", 32'(line_len), 32'(CMAX));
        check("sat_frame_lines", 32'(frame_lines), 32'd1);
`else
        check("sat_line_len", 32'(line_len), 32'd0);
`endif

        // reset while PENDING
        frame(4, 2, CONV_LAT + 6, 1, 0);
        check("pend_before_rst", 32'(cfg_ready), 32'd0);
        rst = 1; step(); rst = 0;
        check("pend_rst_ready", 32'(cfg_ready), 32'd1);
        check("pend_rst_mode", 32'(active_mode), 32'd0);
        check("pend_rst_pixel", 32'(pixel_out), 32'd0);
        check("pend_rst_de", 32'(de_out), 32'd0);

        // randomized frames and config timing
        for (int f = 0; f < 30; f++) begin
            int w, h, off, md, th;
            w  = $urandom_range(1, 8);
            h  = $urandom_range(1, 4);
            off = ($urandom_range(0, 2) != 0) ? $urandom_range(0, 30) : -1;
            md = $urandom_range(0, 3);
            th = $urandom_range(0, 255);
            frame(w, h, off, md, th);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
